// File: rtl/lisp_pkg.sv
// Shared definitions for the lisp machine memory subsystem.
// Holds the word size, the hardware-register window decode and the arbiter enums.
package lisp_pkg;

    localparam int WORD_SIZE = 20;

    // A word address with bits [15:7] == 9'h1FF falls in the hardware-register window.
    localparam logic [8:0] HWREG_PREFIX = 9'h1FF;
    localparam int         HWREG_HI     = 15;
    localparam int         HWREG_LO     = 7;

    typedef enum logic [1:0] {
        ARB_A_PRI,
        ARB_B_FORCED,
        ARB_B_BURST
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_A,
        OWN_B
    } owner_e;

endpackage

// File: rtl/mem_arb_owner_pipe.sv
// Tracks which port owns the read data returning from the memory next cycle
// and steers mem_rdata to that port, holding the other port's data.
module mem_arb_owner_pipe #(
    parameter int WORD_SIZE = lisp_pkg::WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 a_gnt,
    input  logic                 a_we,
    input  logic                 b_gnt,
    input  logic                 b_we,
    input  logic                 b_hwreg,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 a_rvalid,
    output logic [WORD_SIZE-1:0] a_rdata,
    output logic                 b_rvalid,
    output logic [WORD_SIZE-1:0] b_rdata,
    output logic                 b_err
);
    import lisp_pkg::*;

    owner_e               owner_q, owner_d;
    logic                 err_q, err_d;
    logic                 hwrd_q, hwrd_d;
    logic [WORD_SIZE-1:0] a_hold_q, a_hold_d;
    logic [WORD_SIZE-1:0] b_hold_q, b_hold_d;

    always_comb begin
        owner_d = OWN_NONE;
        if (a_gnt && !a_we) begin
            owner_d = OWN_A;
        end else if (b_gnt && !b_we) begin
            owner_d = OWN_B;
        end
        err_d  = b_gnt && b_hwreg;
        hwrd_d = b_gnt && !b_we && b_hwreg;

        // Gated by reset so an access in flight when reset hits never reports.
        a_rvalid = reset_n && (owner_q == OWN_A);
        b_rvalid = reset_n && (owner_q == OWN_B);
        b_err    = reset_n && err_q;

        a_rdata = a_rvalid ? mem_rdata : a_hold_q;
        b_rdata = b_hold_q;
        if (b_rvalid) begin
            b_rdata = hwrd_q ? '0 : mem_rdata;
        end
        a_hold_d = a_rdata;
        b_hold_d = b_rdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner_q  <= OWN_NONE;
            err_q    <= 1'b0;
            hwrd_q   <= 1'b0;
            a_hold_q <= '0;
            b_hold_q <= '0;
        end else begin
            owner_q  <= owner_d;
            err_q    <= err_d;
            hwrd_q   <= hwrd_d;
            a_hold_q <= a_hold_d;
            b_hold_q <= b_hold_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single-port word memory: A has priority, B gets bursts.
// Define MEM_ARB_STARVE_GUARD_EN to add the B starvation guard (ARB_B_FORCED).
module mem_port_arbiter #(
    parameter int WORD_SIZE    = lisp_pkg::WORD_SIZE,
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_BURST    = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 a_req,
    input  logic [WORD_SIZE-1:0] a_addr,
    input  logic                 a_we,
    input  logic [WORD_SIZE-1:0] a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [WORD_SIZE-1:0] a_rdata,
    input  logic                 b_req,
    input  logic [WORD_SIZE-1:0] b_addr,
    input  logic                 b_we,
    input  logic [WORD_SIZE-1:0] b_wdata,
    input  logic                 b_lock,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [WORD_SIZE-1:0] b_rdata,
    output logic                 b_err,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic                 mem_we,
    input  logic [WORD_SIZE-1:0] mem_rdata
);
    import lisp_pkg::*;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve
        $error("STARVE_LIMIT out of range 1..255");
    end
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
        $error("MAX_BURST out of range 1..15");
    end

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    arb_state_e state_q, state_d;
    logic [3:0] burst_q, burst_d;
    logic       use_pri;
    logic       burst_go;
    logic       b_hwreg;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);
    logic [7:0] starve_q, starve_d;
`endif

    assign b_hwreg = (b_addr[HWREG_HI:HWREG_LO] == HWREG_PREFIX);

    always_comb begin
        state_d  = state_q;
        burst_d  = burst_q;
        a_gnt    = 1'b0;
        b_gnt    = 1'b0;
        use_pri  = 1'b0;
        burst_go = b_req && b_lock && (burst_q < BURST_MAX);
`ifdef MEM_ARB_STARVE_GUARD_EN
        starve_d = starve_q;
`endif
        unique case (state_q)
`ifdef MEM_ARB_STARVE_GUARD_EN
            ARB_B_FORCED: begin
                b_gnt    = b_req;
                state_d  = ARB_A_PRI;
                burst_d  = '0;
                starve_d = '0;
            end
`endif
            ARB_B_BURST: begin
                if (burst_go) begin
                    b_gnt   = 1'b1;
                    burst_d = burst_q + 4'd1;
`ifdef MEM_ARB_STARVE_GUARD_EN
                    starve_d = '0;
`endif
                end else begin
                    use_pri = 1'b1;
                end
            end
            default: use_pri = 1'b1;
        endcase

        // A burst that ends falls straight back to fixed priority this cycle.
        if (use_pri) begin
            a_gnt   = a_req;
            b_gnt   = b_req && !a_req;
            state_d = ARB_A_PRI;
            burst_d = '0;
            if (b_gnt && b_lock) begin
                state_d = ARB_B_BURST;
                burst_d = 4'd1;
            end
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (b_req && !b_gnt) begin
                starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 8'd1;
            end else begin
                starve_d = '0;
            end
            if (b_req && (starve_d == STARVE_MAX)) begin
                state_d = ARB_B_FORCED;
            end
`endif
        end

        if (!reset_n) begin
            a_gnt = 1'b0;
            b_gnt = 1'b0;
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (a_gnt) begin
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
            mem_we    = a_we;
        end else if (b_gnt) begin
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
            mem_we    = b_we && !b_hwreg;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ARB_A_PRI;
            burst_q <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve_q <= starve_d;
`endif
        end
    end

    mem_arb_owner_pipe #(
        .WORD_SIZE(WORD_SIZE)
    ) u_owner_pipe (
        .clk      (clk),
        .reset_n  (reset_n),
        .a_gnt    (a_gnt),
        .a_we     (a_we),
        .b_gnt    (b_gnt),
        .b_we     (b_we),
        .b_hwreg  (b_hwreg),
        .mem_rdata(mem_rdata),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .b_err    (b_err)
    );

endmodule
